// File: rtl/seq_alu_if.sv
// Request/response bundle for the sequential ALU.
// The master side issues operations and consumes results.
interface seq_alu_if #(
    parameter int N = 8
);
    logic [3:0]   F;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] y;
    logic [N-1:0] y_hi;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         dz;
    logic         err;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output F, a, b, in_valid, out_ready,
        input  in_ready, y, y_hi, cout, ovf, zero, dz, err, out_valid
    );

    modport slave (
        input  F, a, b, in_valid, out_ready,
        output in_ready, y, y_hi, cout, ovf, zero, dz, err, out_valid
    );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith ops plus iterative
// shift-add multiply and restoring divide, one bit per cycle.
module seq_alu #(
    parameter int N = 8
) (
    input  logic      clk,
    input  logic      reset,
    seq_alu_if.slave  bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic {IDLE, ITER} state_t;

    state_t         state, state_n;
    logic [CW-1:0]  cnt;
    logic           is_div;
    logic [N-1:0]   b_q;
    logic [2*N-1:0] p;
    logic [2*N-1:0] p_n;

    logic [N-1:0]   y_q, hi_q;
    logic           c_q, v_q, z_q, dz_q, err_q, ov_q;

    logic           accept, go_iter, last, done;
    logic           is_mul_in, is_div_in;

    logic [N-1:0]   sc_y, sc_hi;
    logic           sc_c, sc_v, sc_dz, sc_err;
    logic [N:0]     add_s, sub_s;
    logic           add_v, sub_v;

    logic           mc;
    logic [N-1:0]   mhi;
    logic [N:0]     rs, diff;
    logic           ge;

    assign bus.in_ready  = (state == IDLE) && (!ov_q || bus.out_ready);
    assign bus.y         = y_q;
    assign bus.y_hi      = hi_q;
    assign bus.cout      = c_q;
    assign bus.ovf       = v_q;
    assign bus.zero      = z_q;
    assign bus.dz        = dz_q;
    assign bus.err       = err_q;
    assign bus.out_valid = ov_q;

    assign accept    = bus.in_valid && bus.in_ready;
    assign is_mul_in = (bus.F == 4'b1000);
    assign is_div_in = (bus.F == 4'b1001);
    assign go_iter   = is_mul_in || (is_div_in && (bus.b != '0));
    assign last      = (cnt == CW'(N - 1));
    assign done      = (state == ITER) && last;

    // Next-state: iterative ops spend exactly N cycles in ITER
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept && go_iter) state_n = ITER;
            ITER: if (last) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // One multiply or divide step on the shared {hi, lo} register
    always_comb begin
        {mc, mhi} = {1'b0, p[2*N-1:N]} + (p[0] ? {1'b0, b_q} : '0);
        rs        = {p[2*N-1:N], p[N-1]};
        diff      = rs - {1'b0, b_q};
        ge        = !diff[N];
        if (is_div)
            p_n = {(ge ? diff[N-1:0] : rs[N-1:0]), p[N-2:0], ge};
        else
            p_n = {mc, mhi, p[N-1:1]};
    end

    // Single-cycle result from the operands presented on accept
    always_comb begin
        add_s  = {1'b0, bus.a} + {1'b0, bus.b};
        sub_s  = {1'b0, bus.a} + {1'b0, ~bus.b} + (N+1)'(1);
        add_v  = (bus.a[N-1] == bus.b[N-1]) && (add_s[N-1] != bus.a[N-1]);
        sub_v  = (bus.a[N-1] != bus.b[N-1]) && (sub_s[N-1] != bus.a[N-1]);
        sc_y   = '0;
        sc_hi  = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        sc_dz  = 1'b0;
        sc_err = 1'b0;
        case (bus.F)
            4'b0000: sc_y = bus.a & bus.b;
            4'b0001: sc_y = bus.a | bus.b;
            4'b0010: begin
                sc_y = add_s[N-1:0];
                sc_c = add_s[N];
                sc_v = add_v;
            end
            4'b0011: sc_y = bus.a ^ bus.b;
            4'b0100: sc_y = bus.a & ~bus.b;
            4'b0101: sc_y = bus.a | ~bus.b;
            4'b0110: begin
                sc_y = sub_s[N-1:0];
                sc_c = sub_s[N];
                sc_v = sub_v;
            end
            4'b0111: begin
                sc_y = {{(N-1){1'b0}}, sub_s[N-1] ^ sub_v};
                sc_c = sub_s[N];
                sc_v = sub_v;
            end
            4'b1000: sc_y = '0;
            4'b1001: begin
                sc_y  = '1;
                sc_hi = bus.a;
                sc_dz = 1'b1;
            end
            default: sc_err = 1'b1;
        endcase
    end

    // State, iteration datapath and output register
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            b_q    <= '0;
            p      <= '0;
            y_q    <= '0;
            hi_q   <= '0;
            c_q    <= 1'b0;
            v_q    <= 1'b0;
            z_q    <= 1'b0;
            dz_q   <= 1'b0;
            err_q  <= 1'b0;
            ov_q   <= 1'b0;
        end else begin
            state <= state_n;
            if (accept && go_iter) begin
                p      <= {{N{1'b0}}, bus.a};
                b_q    <= bus.b;
                is_div <= is_div_in;
                cnt    <= '0;
            end else if (state == ITER) begin
                p <= p_n;
                if (!last) cnt <= cnt + CW'(1);
            end
            if (accept && !go_iter) begin
                y_q   <= sc_y;
                hi_q  <= sc_hi;
                c_q   <= sc_c;
                v_q   <= sc_v;
                z_q   <= (sc_y == '0);
                dz_q  <= sc_dz;
                err_q <= sc_err;
                ov_q  <= 1'b1;
            end else if (done) begin
                y_q   <= p_n[N-1:0];
                hi_q  <= p_n[2*N-1:N];
                c_q   <= 1'b0;
                v_q   <= 1'b0;
                z_q   <= (p_n[N-1:0] == '0);
                dz_q  <= 1'b0;
                err_q <= 1'b0;
                ov_q  <= 1'b1;
            end else if (ov_q && bus.out_ready) begin
                ov_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// Testbench for seq_alu at N=8: vector table through a
// scoreboard queue, plus back-pressure and reset-abort sequences.
module tb_seq_alu;
    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    seq_alu_if #(.N(8)) bus ();

    seq_alu #(.N(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] f;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y;
        logic [7:0] hi;
        logic       c;
        logic       v;
        logic       z;
        logic       dz;
        logic       err;
        int         lat;
    } vec_t;

    vec_t vt[20];
    vec_t sb[$];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run(input int idx, input vec_t v);
        int   lat;
        logic busy_ok;
        vec_t e;
        @(negedge clk);
        chk($sformatf("v%0d idle_ov", idx), 32'(bus.out_valid), 0);
        chk($sformatf("v%0d in_ready", idx), 32'(bus.in_ready), 1);
        bus.F = v.f;
        bus.a = v.a;
        bus.b = v.b;
        bus.in_valid = 1'b1;
        sb.push_back(v);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.F = 4'($urandom);
        bus.a = 8'($urandom);
        bus.b = 8'($urandom);
        lat = 1;
        busy_ok = 1'b1;
        while (!bus.out_valid && lat < 40) begin
            if (bus.in_ready) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        chk($sformatf("v%0d latency", idx), 32'(lat), 32'(e.lat));
        chk($sformatf("v%0d busy", idx), 32'(busy_ok), 1);
        chk($sformatf("v%0d y", idx), 32'(bus.y), 32'(e.y));
        chk($sformatf("v%0d y_hi", idx), 32'(bus.y_hi), 32'(e.hi));
        chk($sformatf("v%0d flags", idx),
            32'({bus.cout, bus.ovf, bus.zero, bus.dz, bus.err}),
            32'({e.c, e.v, e.z, e.dz, e.err}));
    endtask

    function automatic vec_t mk(input logic [3:0] f, input logic [7:0] a,
                                input logic [7:0] b, input logic [7:0] y,
                                input logic [7:0] hi, input logic [4:0] fl,
                                input int lat);
        vec_t v;
        v.f = f; v.a = a; v.b = b; v.y = y; v.hi = hi;
        {v.c, v.v, v.z, v.dz, v.err} = fl;
        v.lat = lat;
        return v;
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic stale;
        // flags packed as {cout, ovf, zero, dz, err}
        vt[0]  = mk(4'b0010, 8'd200, 8'd100, 8'd44,  8'd0,   5'b10000, 1);
        vt[1]  = mk(4'b0010, 8'd100, 8'd100, 8'd200, 8'd0,   5'b01000, 1);
        vt[2]  = mk(4'b0110, 8'd2,   8'd3,   8'hFF,  8'd0,   5'b00000, 1);
        vt[3]  = mk(4'b0111, 8'h80,  8'h01,  8'd1,   8'd0,   5'b11000, 1);
        vt[4]  = mk(4'b0111, 8'd3,   8'd2,   8'd0,   8'd0,   5'b10100, 1);
        vt[5]  = mk(4'b1000, 8'd200, 8'd200, 8'h40,  8'h9C,  5'b00000, 9);
        vt[6]  = mk(4'b1001, 8'd100, 8'd7,   8'd14,  8'd2,   5'b00000, 9);
        vt[7]  = mk(4'b1001, 8'd100, 8'd0,   8'hFF,  8'd100, 5'b00010, 1);
        vt[8]  = mk(4'b1010, 8'd5,   8'd6,   8'd0,   8'd0,   5'b00101, 1);
        vt[9]  = mk(4'b0000, 8'hF0,  8'h3C,  8'h30,  8'd0,   5'b00000, 1);
        vt[10] = mk(4'b0001, 8'hF0,  8'h0F,  8'hFF,  8'd0,   5'b00000, 1);
        vt[11] = mk(4'b0011, 8'hAA,  8'hFF,  8'h55,  8'd0,   5'b00000, 1);
        vt[12] = mk(4'b0100, 8'hFF,  8'h0F,  8'hF0,  8'd0,   5'b00000, 1);
        vt[13] = mk(4'b0101, 8'h00,  8'hFF,  8'h00,  8'd0,   5'b00100, 1);
        vt[14] = mk(4'b0110, 8'd5,   8'd5,   8'd0,   8'd0,   5'b10100, 1);
        vt[15] = mk(4'b1000, 8'd0,   8'd5,   8'd0,   8'd0,   5'b00100, 9);
        vt[16] = mk(4'b1001, 8'd7,   8'd9,   8'd0,   8'd7,   5'b00100, 9);
        vt[17] = mk(4'b1000, 8'd255, 8'd255, 8'h01,  8'hFE,  5'b00000, 9);
        vt[18] = mk(4'b1001, 8'd255, 8'd1,   8'd255, 8'd0,   5'b00000, 9);
        vt[19] = mk(4'b1111, 8'd1,   8'd1,   8'd0,   8'd0,   5'b00101, 1);

        bus.F = '0;
        bus.a = '0;
        bus.b = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst in_ready", 32'(bus.in_ready), 1);
        chk("rst out_valid", 32'(bus.out_valid), 0);
        chk("rst y", 32'({bus.y, bus.y_hi}), 0);
        chk("rst flags",
            32'({bus.cout, bus.ovf, bus.zero, bus.dz, bus.err}), 0);

        for (int i = 0; i < 20; i++) run(i, vt[i]);

        // back-pressure: hold an OR result, ignore requests meanwhile
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.F = 4'b0001;
        bus.a = 8'h0F;
        bus.b = 8'h30;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.F = 4'b0010;
        bus.a = 8'd9;
        bus.b = 8'd9;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("hold%0d ov", i), 32'(bus.out_valid), 1);
            chk($sformatf("hold%0d y", i), 32'(bus.y), 32'h3F);
            chk($sformatf("hold%0d flags", i),
                32'({bus.cout, bus.ovf, bus.zero, bus.dz, bus.err}), 0);
            chk($sformatf("hold%0d in_ready", i), 32'(bus.in_ready), 0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        bus.a = 8'd1;
        bus.b = 8'd1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("b2b ov", 32'(bus.out_valid), 1);
        chk("b2b y", 32'(bus.y), 2);
        @(negedge clk);
        chk("b2b drained", 32'(bus.out_valid), 0);

        // reset part-way through a multiply
        @(negedge clk);
        bus.F = 4'b1000;
        bus.a = 8'd200;
        bus.b = 8'd200;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort ov", 32'(bus.out_valid), 0);
        chk("abort in_ready", 32'(bus.in_ready), 1);
        chk("abort y", 32'({bus.y, bus.y_hi}), 0);
        chk("abort flags",
            32'({bus.cout, bus.ovf, bus.zero, bus.dz, bus.err}), 0);
        stale = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (bus.out_valid) stale = 1'b1;
            @(negedge clk);
        end
        chk("abort stale", 32'(stale), 0);
        run(20, mk(4'b0010, 8'd1, 8'd2, 8'd3, 8'd0, 5'b00000, 1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
